// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter controller: register offsets,
// FSM encoding and counter indices.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int NCNT        = 4;
  localparam int CNT_CYCLE   = 0;
  localparam int CNT_INSTRET = 1;
  localparam int CNT_BRPRED  = 2;
  localparam int CNT_BRMISP  = 3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Byte offsets; the top truncates them to its window width.
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STAT   = 8'h04;
  localparam logic [7:0] OFF_HALT   = 8'h08;
  localparam logic [7:0] OFF_CYC_LO = 8'h10;
  localparam logic [7:0] OFF_CYC_HI = 8'h14;
  localparam logic [7:0] OFF_RET_LO = 8'h18;
  localparam logic [7:0] OFF_RET_HI = 8'h1C;
  localparam logic [7:0] OFF_BRP_LO = 8'h20;
  localparam logic [7:0] OFF_BRP_HI = 8'h24;
  localparam logic [7:0] OFF_MSP_LO = 8'h28;
  localparam logic [7:0] OFF_MSP_HI = 8'h2C;

endpackage

// File: rtl/perf_cnt64.sv
// Free-running wrap-around event counter; a clear beats an increment in the
// same cycle.
module perf_cnt64 #(
  parameter int CW = 64
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_ctrl.sv
// MMIO controller for the cycle / instret / branch / mispredict counters:
// run-control FSM, register decode, hi-word shadow and registered read port.
module perf_ctrl
  import perf_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CW     = 64
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wvalid_i,
  input  logic              rvalid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rack_o,
  input  logic              ev_retire_i,
  input  logic              ev_br_i,
  input  logic              ev_misp_i,
  output logic              fini_o,
  output logic [1:0]        state_o
);

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       rdata_q;
  logic              rack_q;
  logic [31:0]       rd_mux;
  logic [ADDR_W-1:0] word_addr;
  logic              wr_ctrl, wr_halt, run, clr;
  logic [NCNT-1:0]   inc;
  logic [CW-1:0]     cnt [NCNT];
  logic              unused_wdata;

  function automatic logic [31:0] lo_w(input logic [CW-1:0] c);
    return 32'(c);
  endfunction

  function automatic logic [31:0] hi_w(input logic [CW-1:0] c);
    return 32'(c >> 32);
  endfunction

  assign word_addr    = addr_i & ~ADDR_W'(3);
  assign wr_ctrl      = wvalid_i && (word_addr == ADDR_W'(OFF_CTRL));
  assign wr_halt      = wvalid_i && (word_addr == ADDR_W'(OFF_HALT));
  assign unused_wdata = ^wdata_i[31:2];

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_halt) state_d = ST_HALT;
        else if (wr_ctrl && wdata_i[CTRL_EN_BIT]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_halt) state_d = ST_HALT;
        else if (wr_ctrl && !wdata_i[CTRL_EN_BIT]) state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // Once halted the control register is dead: no enable change, no clear.
    if (wr_ctrl && state_q != ST_HALT) begin
      en_d = wdata_i[CTRL_EN_BIT];
      clr  = wdata_i[CTRL_CLR_BIT];
    end
  end

  assign run               = (state_q == ST_RUN);
  assign inc[CNT_CYCLE]    = run;
  assign inc[CNT_INSTRET]  = run && ev_retire_i;
  assign inc[CNT_BRPRED]   = run && ev_br_i;
  assign inc[CNT_BRMISP]   = run && ev_br_i && ev_misp_i;

  perf_cnt64 #(.CW(CW)) u_cycle (
    .clk_i(clk_i), .rst_n(rst_n), .inc_i(inc[CNT_CYCLE]), .clr_i(clr), .cnt_o(cnt[CNT_CYCLE])
  );
  perf_cnt64 #(.CW(CW)) u_instret (
    .clk_i(clk_i), .rst_n(rst_n), .inc_i(inc[CNT_INSTRET]), .clr_i(clr), .cnt_o(cnt[CNT_INSTRET])
  );
  perf_cnt64 #(.CW(CW)) u_brpred (
    .clk_i(clk_i), .rst_n(rst_n), .inc_i(inc[CNT_BRPRED]), .clr_i(clr), .cnt_o(cnt[CNT_BRPRED])
  );
  perf_cnt64 #(.CW(CW)) u_brmisp (
    .clk_i(clk_i), .rst_n(rst_n), .inc_i(inc[CNT_BRMISP]), .clr_i(clr), .cnt_o(cnt[CNT_BRMISP])
  );

  // A lo read snapshots the same counter's hi word so the following hi read
  // (of any counter) returns a consistent 64-bit value.
  always_comb begin
    rd_mux   = '0;
    shadow_d = shadow_q;
    case (word_addr)
      ADDR_W'(OFF_CTRL): rd_mux = {31'd0, en_q};
      ADDR_W'(OFF_STAT): rd_mux = {30'd0, state_q};
      ADDR_W'(OFF_CYC_LO): begin
        rd_mux   = lo_w(cnt[CNT_CYCLE]);
        shadow_d = hi_w(cnt[CNT_CYCLE]);
      end
      ADDR_W'(OFF_RET_LO): begin
        rd_mux   = lo_w(cnt[CNT_INSTRET]);
        shadow_d = hi_w(cnt[CNT_INSTRET]);
      end
      ADDR_W'(OFF_BRP_LO): begin
        rd_mux   = lo_w(cnt[CNT_BRPRED]);
        shadow_d = hi_w(cnt[CNT_BRPRED]);
      end
      ADDR_W'(OFF_MSP_LO): begin
        rd_mux   = lo_w(cnt[CNT_BRMISP]);
        shadow_d = hi_w(cnt[CNT_BRMISP]);
      end
      ADDR_W'(OFF_CYC_HI), ADDR_W'(OFF_RET_HI),
      ADDR_W'(OFF_BRP_HI), ADDR_W'(OFF_MSP_HI): rd_mux = shadow_q;
      default: rd_mux = '0;
    endcase
    if (!rvalid_i) shadow_d = shadow_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      shadow_q <= '0;
      rdata_q  <= '0;
      rack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      shadow_q <= shadow_d;
      rack_q   <= rvalid_i;
      rdata_q  <= rvalid_i ? rd_mux : '0;
    end
  end

  assign rdata_o = rdata_q;
  assign rack_o  = rack_q;
  assign fini_o  = (state_q == ST_HALT);
  assign state_o = state_q;

endmodule

// File: tb/tb_perf_ctrl.sv
// Scoreboard bench for perf_ctrl: reads push their expected data, a monitor
// pops and compares when rack_o rises.
module tb_perf_ctrl;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STAT   = 6'h04;
  localparam logic [5:0] A_HALT   = 6'h08;
  localparam logic [5:0] A_CYC_LO = 6'h10;
  localparam logic [5:0] A_CYC_HI = 6'h14;
  localparam logic [5:0] A_RET_LO = 6'h18;
  localparam logic [5:0] A_RET_HI = 6'h1C;
  localparam logic [5:0] A_BRP_LO = 6'h20;
  localparam logic [5:0] A_MSP_LO = 6'h28;
  localparam logic [5:0] A_MSP_HI = 6'h2C;
  localparam logic [5:0] A_UNMAP  = 6'h30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wvalid = 1'b0;
  logic        rvalid = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ev_retire = 1'b0;
  logic        ev_br = 1'b0;
  logic        ev_misp = 1'b0;
  logic [31:0] rdata;
  logic        rack;
  logic        fini;
  logic [1:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_d;
  logic        was_rd;

  perf_ctrl #(.ADDR_W(6), .CW(64)) dut (
    .clk_i(clk), .rst_n(rst_n), .wvalid_i(wvalid), .rvalid_i(rvalid),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rack_o(rack),
    .ev_retire_i(ev_retire), .ev_br_i(ev_br), .ev_misp_i(ev_misp),
    .fini_o(fini), .state_o(state)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wvalid = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e);
    rvalid = 1'b1; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      was_rd = rvalid && rst_n;
      #1;
      checks++;
      if (rack !== was_rd) begin
        errors++;
        $display("FAIL rack_timing: rack_o=%b, required %b at %0t", rack, was_rd, $time);
      end
      if (rack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rack_unexpected: rdata_o=%h with no read outstanding at %0t", rdata, $time);
        end else begin
          exp_d = exp_q.pop_front();
          if (rdata !== exp_d) begin
            errors++;
            $display("FAIL rdata: got %h, required %h at %0t", rdata, exp_d, $time);
          end
        end
      end else begin
        checks++;
        if (rdata !== 32'h0) begin
          errors++;
          $display("FAIL rdata_idle: got %h, required 0 at %0t", rdata, $time);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({fini, state, rack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: fini/state/rack=%b, required 0000", {fini, state, rack});
    end
    rst_n = 1'b1;
    idle(1);
    rd(A_CYC_LO, 32'h0);
    rd(A_STAT, 32'h0);
    wr(A_CYC_LO, 32'h55);
    wr(A_STAT, 32'h2);
    rd(A_CYC_LO, 32'h0);
    rd(A_STAT, 32'h0);
    rd(A_UNMAP, 32'h0);
    checks++;
    if (fini !== 1'b0) begin
      errors++;
      $display("FAIL reset_fini: got %b, required 0", fini);
    end
  endtask

  task automatic test_instret();
    wr(A_CTRL, 32'h1);
    ev_retire = 1'b1;
    idle(10);
    ev_retire = 1'b0;
    wr(A_CTRL, 32'h0);
    rd(A_RET_LO, 32'd10);
    rd(A_RET_HI, 32'd0);
    rd(A_CYC_LO, 32'd11);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL instret_state: got %0d, required 0", state);
    end
  endtask

  task automatic test_branch();
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      ev_br = 1'b1;
      ev_misp = (i < 2);
      @(negedge clk);
    end
    ev_br = 1'b0;
    ev_misp = 1'b1;
    @(negedge clk);
    ev_misp = 1'b0;
    wr(A_CTRL, 32'h0);
    rd(A_BRP_LO, 32'd5);
    rd(A_MSP_LO, 32'd2);
    rd(A_MSP_HI, 32'd0);
    rd(A_CYC_LO, 32'd18);
    rd(A_RET_LO, 32'd10);
  endtask

  task automatic test_rw_same_cycle();
    rvalid = 1'b1; wvalid = 1'b1; addr = A_CTRL; wdata = 32'h1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    rvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL rw_state: got %0d, required 1", state);
    end
    rd(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL rw_state_idle: got %0d, required 0", state);
    end
  endtask

  task automatic test_wrap();
    force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFE;
    idle(2);
    release dut.u_cycle.cnt_q;
    wr(A_CTRL, 32'h1);
    idle(2);
    wr(A_CTRL, 32'h0);
    rd(A_CYC_LO, 32'h1);
    rd(A_CYC_HI, 32'h1);
    rd(A_CYC_HI, 32'h1);
    rd(A_CYC_HI, 32'h1);
    rd(A_RET_HI, 32'h1);
    force dut.u_cycle.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(2);
    release dut.u_cycle.cnt_q;
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    rd(A_CYC_LO, 32'h0);
    rd(A_CYC_HI, 32'h0);
  endtask

  task automatic test_clear();
    wr(A_CTRL, 32'h1);
    ev_retire = 1'b1;
    idle(2);
    wr(A_CTRL, 32'h3);
    ev_retire = 1'b0;
    rd(A_RET_LO, 32'd0);
    rd(A_BRP_LO, 32'd0);
    ev_retire = 1'b1;
    idle(3);
    ev_retire = 1'b0;
    rd(A_RET_LO, 32'd3);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL clear_state: got %0d, required 1", state);
    end
  endtask

  task automatic test_halt_reset();
    wr(A_HALT, 32'h0);
    checks++;
    if (fini !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL halt_enter: fini=%b state=%0d, required fini=1 state=2", fini, state);
    end
    ev_retire = 1'b1; ev_br = 1'b1;
    wr(A_CTRL, 32'h3);
    idle(2);
    ev_retire = 1'b0; ev_br = 1'b0;
    rd(A_CYC_LO, 32'd7);
    rd(A_RET_LO, 32'd3);
    rd(A_CYC_HI, 32'd0);
    rd(A_STAT, 32'd2);
    checks++;
    if (fini !== 1'b1) begin
      errors++;
      $display("FAIL halt_sticky: fini=%b, required 1", fini);
    end
    rvalid = 1'b1; addr = A_CYC_LO;
    rst_n = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    idle(1);
    checks++;
    if ({fini, state, rack} !== 4'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset: fini/state/rack=%b rdata=%h, required 0000 and 0", {fini, state, rack}, rdata);
    end
    rst_n = 1'b1;
    idle(1);
    rd(A_CYC_LO, 32'd0);
    rd(A_RET_LO, 32'd0);
    rd(A_CYC_HI, 32'd0);
    rd(A_STAT, 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_instret();
    test_branch();
    test_rw_same_cycle();
    test_wrap();
    test_clear();
    test_halt_reset();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads unanswered, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
